funcase_sched: RTL



---
 rtl/funcase_pkg.sv | 8 +
 rtl/funcase_rr_arb.sv | 28 ++
 rtl/funcase_sched.sv | 82 ++++++++
 3 files changed

// File: rtl/funcase_pkg.sv
// funcase_pkg: shared state encoding and the 2-bit hit classifier
package funcase_pkg;
  typedef enum logic [1:0] {IDLE, EVAL, RESP} sched_state_t;
  localparam logic [1:0] CLASS_HIT_CODE = 2'h3;
  function automatic logic classify(input logic [1:0] code);
    return code == CLASS_HIT_CODE;
  endfunction
endpackage

// File: rtl/funcase_rr_arb.sv
// funcase_rr_arb: round-robin winner search starting just after the last grant
module funcase_rr_arb #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   last,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_id
);
  int   idx;
  logic found;
  // first valid requester scanning (last+1) upward with wrap; grant only when enabled
  always_comb begin
    idx = 0;
    found = 1'b0;
    grant_id = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant_id = IW'(idx);
      end
    end
    grant = (enable && found) ? NREQ'(1) << grant_id : '0;
  end
endmodule

// File: rtl/funcase_sched.sv
// funcase_sched: shares one registered code classifier among NREQ requesters
module funcase_sched
  import funcase_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CNT_W = 8,
  localparam int IW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IW-1:0]     res_id,
  output logic              res_bit,
  output logic              busy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  hit_count
);
  sched_state_t     state_q;
  logic [IW-1:0]    last_q, id_q, res_id_q, grant_id;
  logic [1:0]       code_q;
  logic             res_bit_q, arb_en, accept;
  logic [NREQ-1:0]  grant;
  logic [CNT_W-1:0] hit_q, hit_d;

  assign arb_en = !rst && (state_q == IDLE || (state_q == RESP && res_ready));
  assign accept = |(req_valid & grant);

  funcase_rr_arb #(.NREQ(NREQ)) u_arb (
    .req_valid(req_valid),
    .last(last_q),
    .enable(arb_en),
    .grant(grant),
    .grant_id(grant_id)
  );

  assign req_ready = grant;
  assign res_valid = state_q == RESP;
  assign busy = state_q != IDLE;
  assign res_id = res_id_q;
  assign res_bit = res_bit_q;
  assign hit_count = hit_q;

  // scheduler FSM: latch accepted code, classify in EVAL, hold result in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= IW'(NREQ - 1);
      code_q <= '0;
      id_q <= '0;
      res_id_q <= '0;
      res_bit_q <= 1'b0;
    end else begin
      if (accept) begin
        code_q <= req_data[2*grant_id +: 2];
        id_q <= grant_id;
        last_q <= grant_id;
      end
      if (state_q == EVAL) begin
        res_bit_q <= classify(code_q);
        res_id_q <= id_q;
      end
      state_q <= accept ? EVAL
               : state_q == EVAL ? RESP
               : (state_q == RESP && !res_ready) ? RESP
               : IDLE;
    end
  end

  assign hit_d = cnt_clr ? '0
               : (state_q == RESP && res_ready && res_bit_q && hit_q != '1) ? hit_q + 1'b1
               : hit_q;

  // saturating count of consumed hit results; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst) hit_q <= '0;
    else hit_q <= hit_d;
  end
endmodule
